// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : MIPS ALU execute stage with a multi-cycle multiply-accumulate unit.
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUop,
   input  logic [5:0]       FuncCode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             illegal
);

   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] c_OP_AND   = 4'b0000;
   localparam logic [3:0] c_OP_OR    = 4'b0001;
   localparam logic [3:0] c_OP_ADD   = 4'b0010;
   localparam logic [3:0] c_OP_SLL   = 4'b0011;
   localparam logic [3:0] c_OP_SRL   = 4'b0100;
   localparam logic [3:0] c_OP_MULA  = 4'b0101;
   localparam logic [3:0] c_OP_SUB   = 4'b0110;
   localparam logic [3:0] c_OP_SLT   = 4'b0111;
   localparam logic [3:0] c_OP_ADDU  = 4'b1000;
   localparam logic [3:0] c_OP_SUBU  = 4'b1001;
   localparam logic [3:0] c_OP_XOR   = 4'b1010;
   localparam logic [3:0] c_OP_SLTU  = 4'b1011;
   localparam logic [3:0] c_OP_NOR   = 4'b1100;
   localparam logic [3:0] c_OP_SRA   = 4'b1101;
   localparam logic [3:0] c_OP_LUI   = 4'b1110;
   localparam logic [3:0] c_OP_RTYPE = 4'b1111;

   localparam logic [WIDTH-1:0] c_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SHW:0]     c_COUNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0]     c_COUNT_ONE  = (SHW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_prod;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [SHW:0]     r_count;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_illegal;
   logic             r_out_valid;

   logic [3:0]       w_op;
   logic             w_illegal;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_negb;
   logic [SHW-1:0]   w_shamt;
   logic             w_slt;
   logic             w_sltu;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic             w_zero;
   logic             w_is_mula;
   logic [WIDTH-1:0] w_step;

   always_comb begin
      w_op      = ALUop;
      w_illegal = 1'b0;
      if (ALUop == c_OP_RTYPE) begin
         case (FuncCode)
            6'b000000: w_op = c_OP_SLL;
            6'b000010: w_op = c_OP_SRL;
            6'b000011: w_op = c_OP_SRA;
            6'b100000: w_op = c_OP_ADD;
            6'b100001: w_op = c_OP_ADDU;
            6'b100010: w_op = c_OP_SUB;
            6'b100011: w_op = c_OP_SUBU;
            6'b100100: w_op = c_OP_AND;
            6'b100101: w_op = c_OP_OR;
            6'b100110: w_op = c_OP_XOR;
            6'b100111: w_op = c_OP_NOR;
            6'b101010: w_op = c_OP_SLT;
            6'b101011: w_op = c_OP_SLTU;
            6'b111000: w_op = c_OP_MULA;
            default: begin
               w_op      = c_OP_AND;
               w_illegal = 1'b1;
            end
         endcase
      end
   end

   assign w_sum   = A + B;
   assign w_diff  = A - B;
   assign w_negb  = ~B + c_ONE;
   assign w_shamt = A[SHW-1:0];
   assign w_slt   = $signed(A) < $signed(B);
   assign w_sltu  = A < B;

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (w_op)
         c_OP_AND:  w_res = A & B;
         c_OP_OR:   w_res = A | B;
         c_OP_XOR:  w_res = A ^ B;
         c_OP_NOR:  w_res = ~(A | B);
         c_OP_ADD: begin
            w_res = w_sum;
            w_ovf = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
         end
         c_OP_SUB: begin
            w_res = w_diff;
            w_ovf = (A[MSB] == w_negb[MSB]) && (w_diff[MSB] != A[MSB]);
         end
         c_OP_ADDU: w_res = w_sum;
         c_OP_SUBU: w_res = w_diff;
         c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
         c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
         c_OP_SLL:  w_res = B << w_shamt;
         c_OP_SRL:  w_res = B >> w_shamt;
         c_OP_SRA:  w_res = $signed(B) >>> w_shamt;
         c_OP_LUI:  w_res = B << (WIDTH / 2);
         default:   w_res = '0;
      endcase
      if (w_illegal) begin
         w_res = '0;
         w_ovf = 1'b0;
      end
   end

   assign w_zero    = (w_res == '0);
   assign w_is_mula = (w_op == c_OP_MULA) && !w_illegal;
   // Product register is seeded with the accumulator, so the last step yields acc + A*B.
   assign w_step    = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_prod      <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_count     <= '0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_illegal   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (acc_clr) begin
                  r_acc <= '0;
               end
               if (in_valid) begin
                  if (w_is_mula) begin
                     r_prod   <= acc_clr ? '0 : r_acc;
                     r_mcand  <= A;
                     r_mplier <= B;
                     r_count  <= c_COUNT_INIT;
                     r_state  <= S_MUL;
                  end else begin
                     r_result    <= w_res;
                     r_zero      <= w_zero;
                     r_ovf       <= w_ovf;
                     r_illegal   <= w_illegal;
                     r_out_valid <= 1'b1;
                     r_state     <= S_OUT;
                  end
               end
            end
            S_MUL: begin
               r_prod   <= w_step;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count - c_COUNT_ONE;
               if (r_count == c_COUNT_ONE) begin
                  r_result    <= w_step;
                  r_acc       <= w_step;
                  r_zero      <= (w_step == '0);
                  r_ovf       <= 1'b0;
                  r_illegal   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = Reset_L && (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed vector bench for alu_exec_unit (WIDTH=32).
// Revision : 1.0
// ============================================================================
module tb_alu_exec_unit;

   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          Reset_L = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    ALUop = 4'h0;
   logic [5:0]    FuncCode = 6'h0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          acc_clr = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          zero;
   logic          ovf;
   logic          illegal;

   int total = 0;
   int bad   = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .CLK      (CLK),
      .Reset_L  (Reset_L),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ALUop    (ALUop),
      .FuncCode (FuncCode),
      .A        (A),
      .B        (B),
      .acc_clr  (acc_clr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .zero     (zero),
      .ovf      (ovf),
      .illegal  (illegal)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]   aluop;
      logic [5:0]   func;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         o;
      logic         ill;
   } vec_t;

   vec_t vecs[28];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Presents one bundle, waits for the result, captures it and lets the unit return to IDLE.
   task automatic run_op(input logic [3:0] op, input logic [5:0] fc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic clr,
                         output logic [W-1:0] r, output logic z, output logic o,
                         output logic il, output int edges, output logic rdy_seen);
      int w = 0;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      ALUop    = op;
      FuncCode = fc;
      A        = a;
      B        = b;
      acc_clr  = clr;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      edges    = 0;
      rdy_seen = 1'b0;
      while (!out_valid && edges < 200) begin
         tick();
         edges++;
         if (in_ready) rdy_seen = 1'b1;
      end
      chk("out_valid_arrives", {31'd0, out_valid}, 32'd1);
      r  = result;
      z  = zero;
      o  = ovf;
      il = illegal;
      tick();
   endtask

   initial begin
      logic [W-1:0] r;
      logic         z, o, il, rs;
      int           ed;

      vecs[0]  = '{4'hF, 6'h20, 32'd5, 32'd7, 32'h0000000C, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'hF, 6'h22, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{4'hF, 6'h24, 32'd5, 32'd7, 32'h00000005, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{4'hF, 6'h25, 32'd5, 32'd7, 32'h00000007, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'hF, 6'h26, 32'd5, 32'd7, 32'h00000002, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'hF, 6'h27, 32'd5, 32'd7, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{4'hF, 6'h3F, 32'd5, 32'd7, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{4'h6, 6'h00, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{4'h9, 6'h00, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{4'h2, 6'h00, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{4'h7, 6'h00, 32'hFFFFFFFF, 32'd1, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{4'hB, 6'h00, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{4'hD, 6'h00, 32'd4, 32'hF0000000, 32'hFF000000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{4'h4, 6'h00, 32'd4, 32'hF0000000, 32'h0F000000, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{4'h3, 6'h00, 32'd33, 32'd1, 32'h00000002, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{4'hE, 6'h00, 32'd0, 32'h1234, 32'h12340000, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{4'h2, 6'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{4'hF, 6'h21, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{4'hF, 6'h00, 32'd4, 32'd3, 32'h00000030, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{4'hF, 6'h03, 32'd1, 32'h80000000, 32'hC0000000, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{4'hF, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{4'h0, 6'h00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{4'h8, 6'h00, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{4'hF, 6'h23, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[24] = '{4'h1, 6'h00, 32'd0, 32'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[25] = '{4'hA, 6'h00, 32'hF0, 32'hFF, 32'h0000000F, 1'b0, 1'b0, 1'b0};
      vecs[26] = '{4'hC, 6'h00, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[27] = '{4'hF, 6'h02, 32'd31, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0};

      // Reset held for two edges
      Reset_L = 1'b0;
      tick();
      tick();
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.result", result, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
      Reset_L = 1'b1;
      #1;
      chk("rst_release.in_ready", {31'd0, in_ready}, 32'd1);

      // Accumulator starts at zero after reset
      run_op(4'h5, 6'h00, 32'd2, 32'd3, 1'b0, r, z, o, il, ed, rs);
      chk("post_rst_mula.res", r, 32'd6);

      for (int i = 0; i < 28; i++) begin
         run_op(vecs[i].aluop, vecs[i].func, vecs[i].a, vecs[i].b, 1'b0, r, z, o, il, ed, rs);
         chk($sformatf("vec%0d.res", i), r, vecs[i].res);
         chk($sformatf("vec%0d.zero", i), {31'd0, z}, {31'd0, vecs[i].z});
         chk($sformatf("vec%0d.ovf", i), {31'd0, o}, {31'd0, vecs[i].o});
         chk($sformatf("vec%0d.illegal", i), {31'd0, il}, {31'd0, vecs[i].ill});
         chk($sformatf("vec%0d.edges_after_accept", i), ed, 32'd0);
      end

      // MULA accumulation
      run_op(4'h5, 6'h00, 32'd3, 32'd4, 1'b1, r, z, o, il, ed, rs);
      chk("mula1.res", r, 32'd12);
      chk("mula1.edges_after_accept", ed, 32'd32);
      chk("mula1.in_ready_seen_busy", {31'd0, rs}, 32'd0);
      chk("mula1.ovf", {31'd0, o}, 32'd0);
      run_op(4'h5, 6'h00, 32'd5, 32'd6, 1'b0, r, z, o, il, ed, rs);
      chk("mula2.res", r, 32'd42);
      run_op(4'h2, 6'h00, 32'd100, 32'd1, 1'b0, r, z, o, il, ed, rs);
      chk("add_between.res", r, 32'd101);
      run_op(4'h5, 6'h00, 32'd2, 32'd2, 1'b1, r, z, o, il, ed, rs);
      chk("mula_clr.res", r, 32'd4);
      run_op(4'hF, 6'h38, 32'd1, 32'd1, 1'b0, r, z, o, il, ed, rs);
      chk("mula_rtype.res", r, 32'd5);
      chk("mula_rtype.edges_after_accept", ed, 32'd32);
      run_op(4'h5, 6'h00, 32'h00010000, 32'h00010003, 1'b1, r, z, o, il, ed, rs);
      chk("mula_wrap.res", r, 32'h00030000);

      // Backpressure: ADD held with out_ready low, a second op waiting
      out_ready = 1'b0;
      ALUop = 4'h2; FuncCode = 6'h00; A = 32'd5; B = 32'd7;
      in_valid = 1'b1;
      tick();
      ALUop = 4'h1; A = 32'd1; B = 32'd2;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d.out_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d.result", k), result, 32'd12);
         chk($sformatf("bp%0d.flags", k), {29'd0, zero, ovf, illegal}, 32'd0);
         chk($sformatf("bp%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release.in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_release.out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bp_pending.out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_pending.result", result, 32'd3);
      tick();

      // Reset in the middle of a MULA
      run_op(4'h5, 6'h00, 32'd5, 32'd5, 1'b1, r, z, o, il, ed, rs);
      chk("pre_abort.res", r, 32'd25);
      ALUop = 4'h5; A = 32'd7; B = 32'd7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      Reset_L = 1'b0;
      tick();
      chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort.in_ready_low", {31'd0, in_ready}, 32'd0);
      Reset_L = 1'b1;
      #1;
      chk("abort.idle", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (out_valid) chk($sformatf("abort.stale_out%0d", k), {31'd0, out_valid}, 32'd0);
      end
      run_op(4'h5, 6'h00, 32'd2, 32'd3, 1'b0, r, z, o, il, ed, rs);
      chk("post_abort_mula.res", r, 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
